// File: rtl/mul_accum_if.sv
// Product-in / result-out handshake bundle for the multiply-accumulate back end.
// master drives products and consumes results; slave is the accumulator.
interface mul_accum_if #(
    parameter int N         = 4,
    parameter int ACC_W     = 16,
    parameter int MAX_TERMS = 8
);
    localparam int CW = $clog2(MAX_TERMS + 1);

    logic             prod_valid;
    logic             prod_ready;
    logic [2*N-1:0]   prod;
    logic             prod_last;

    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CW-1:0]    out_count;
    logic             out_ovf;

    modport master (
        output prod_valid, prod, prod_last, out_ready,
        input  prod_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport slave (
        input  prod_valid, prod, prod_last, out_ready,
        output prod_ready, out_valid, out_sum, out_count, out_ovf
    );
endinterface

// File: rtl/mul_accum.sv
// Sums groups of unsigned products (closed by prod_last or MAX_TERMS); MUL_ACCUM_SAT_EN selects clamp vs wrap.
// Latency: result valid 1 cycle after the closing accept; one product per cycle while gathering.
// Backpressure: result held while out_ready is low; prod_ready is 0 until the result is taken.
module mul_accum #(
    parameter int N         = 4,
    parameter int ACC_W     = 16,
    parameter int MAX_TERMS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    mul_accum_if.slave bus
);
    localparam int CW  = $clog2(MAX_TERMS + 1);
    localparam int PAD = ACC_W + 1 - 2*N;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_TERMS);

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W:0]   sum_ext;
    logic             accept;

    assign bus.prod_ready = (state_q == ACC) && rst_n;
    assign bus.out_valid  = (state_q == DONE);
    assign bus.out_sum    = acc_q;
    assign bus.out_count  = cnt_q;
    assign bus.out_ovf    = ovf_q;

    assign accept  = bus.prod_valid && bus.prod_ready;
    // One extra bit catches the carry out of the accumulator.
    assign sum_ext = {1'b0, acc_q} + {{PAD{1'b0}}, bus.prod};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            ACC: begin
                if (accept) begin
`ifdef MUL_ACCUM_SAT_EN
                    // Once clamped, any further nonzero term carries out again, so it stays pinned.
                    acc_d = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
                    acc_d = sum_ext[ACC_W-1:0];
`endif
                    cnt_d = cnt_q + CW'(1);
                    ovf_d = ovf_q | sum_ext[ACC_W];
                    if (bus.prod_last || (cnt_d == MAX_CNT)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ACC;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end
endmodule

// File: doc/mul_accum.md
# mul_accum

Accumulator stage that sits directly downstream of the array multiplier. It consumes a stream of 2N-bit products over a valid/ready handshake and sums each group of products into an ACC_W-bit accumulator. A group is closed by a last flag or by reaching MAX_TERMS products, and the block then presents the sum, the term count and an overflow flag on a second valid/ready handshake. It is the dot-product back end for the multiplier datapath.

## Interface
- N, 4: multiplier operand width; products are 2N bits.
- ACC_W, 16: accumulator width; must be ≥ 2N.
- MAX_TERMS, 8: maximum products per group; must be ≥ 1.
- CW (localparam), $clog2(MAX_TERMS+1): count width.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, synchronous and active-low.
- prod_valid  input  1  prod and prod_last are valid.
- prod_ready  output  1  block accepts a product this cycle.
- prod  input  2N  unsigned product from the multiplier.
- prod_last  input  1  final product of the current group.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  ACC_W  accumulated sum of the group.
- out_count  output  CW  number of products in the group.
- out_ovf  output  1  sticky: the group overflowed ACC_W.

## Operation
- Two states: ACC (gathering products) and DONE (holding the result). Reset enters ACC.
- prod_ready = (state == ACC) && rst_n. out_valid = (state == DONE).
- **Accept** happens when prod_valid && prod_ready:
  - Zero-extend prod to ACC_W+1 bits and add it to the accumulator.
  - Increment the count.
  - Set out_ovf if bit ACC_W of the sum is 1.
- **Group close**: an accept with prod_last = 1, or an accept that makes count == MAX_TERMS, moves the block to DONE.
- **DONE**:
  - out_sum, out_count and out_ovf are held stable.
  - prod_ready is 0, so no product is accepted.
- **Release**: out_valid && out_ready clears the accumulator, count and out_ovf to 0 and returns the block to ACC. A new product is accepted no earlier than the next cycle.
- Cycles with prod_valid low in ACC leave all state unchanged.
- A zero-term group does not exist. The block leaves ACC only through an accept.
- Arithmetic is unsigned. Wrap behaviour is modulo 2^ACC_W unless saturation is configured (see Configuration).
- prod_last together with count reaching MAX_TERMS on the same accept closes the group exactly once.

## Timing
- Reset values: out_valid 0, out_sum 0, out_count 0, out_ovf 0, prod_ready 0 while rst_n is low. prod_ready is 1 on the first cycle after rst_n is high.
- Reset asserted mid-group or in DONE discards everything on the next edge. No partial result is emitted.
- Throughput is one product per cycle while in ACC.
- Latency is 1 cycle: the closing accept at edge k gives out_valid = 1 and the final out_sum after edge k.
- Minimum group-to-group gap is one cycle with prod_ready low, when out_ready is already high.
- Backpressure: with out_ready low, DONE holds indefinitely and prod_ready stays 0.

## Configuration
- **MUL_ACCUM_SAT_EN**
  - Defined: on an overflowing accept, the accumulator clamps to 2^ACC_W − 1 and stays there for the rest of the group. out_ovf is set.
  - Undefined: the accumulator wraps modulo 2^ACC_W and out_ovf is set.
- out_count and the handshake behave identically in both builds.

## Test plan
- Four products of 225, with prod_last on the 4th and out_ready = 1: out_sum 900, out_count 4, out_ovf 0, out_valid for one cycle.
- MAX_TERMS = 8, eight products of 1 with prod_last = 0: the group closes after the 8th, giving out_sum 8 and out_count 8. The 9th product is not accepted until release.
- out_ready held low 5 cycles after close: out_valid stays 1, outputs are stable, prod_ready is 0 throughout. The group releases on the cycle out_ready goes high.
- ACC_W = 10, five products of 225 (total 1125):
  - Without MUL_ACCUM_SAT_EN: out_sum 101, out_ovf 1.
  - With MUL_ACCUM_SAT_EN: out_sum 1023, out_ovf 1.
- Two products accepted, then rst_n low for one cycle: all outputs read 0. The next group of a single 7 with last gives out_sum 7, out_count 1.
- Products 3, 5, 9 with random prod_valid bubbles between them: out_sum 17, out_count 3, the same result as the bubble-free case.
